pcie_tx_serializer: RTL
=======================

# pcie_tx_serializer

Transmit-side parallel-to-serial stage of the PCIe PHY path, running on the fast bit clock `clock32`. Accepts 8-bit symbols from the byte-rate logic through a valid/ready handshake, buffers them in a small FIFO, and shifts them out one bit per `clock32` cycle, LSB first. An internal 3-bit bit counter defines byte slots of 8 cycles, which is the same 1/8 ratio as `clock4`. The stage is the consumer of the divided-clock domain's byte stream and feeds the serial line driver.

## Interface
- `FIFO_DEPTH`, 4: symbol buffer depth. Must be a power of two, ≥2.
- `IDLE_BYTE`, 8'hBC: symbol sent in empty slots when idle fill is compiled in.
- `clock32` input 1: bit clock. The only clock; all logic is on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `data_in` input 8: symbol to transmit.
- `valid_in` input 1: `data_in` is valid.
- `ready_out` output 1: FIFO can accept. Combinational: count < `FIFO_DEPTH`.
- `serial_out` output 1: current line bit, `shift_reg[0]`.
- `serial_valid` output 1: the current slot carries a symbol (data, or idle when fill is enabled).
- `byte_strobe` output 1: high on bit 0 of each valid slot.

## Operation
- Push: the FIFO writes `data_in` on any edge where `valid_in && ready_out`. There is no write when full, and no bypass path.
- `bit_cnt` (3 bits) is free-running from 0 after reset and wraps 7→0.
- Load edge: an edge where `bit_cnt==7`.
  - FIFO non-empty: pop the head into `shift_reg` and set `slot_valid=1`.
  - FIFO empty, fill enabled: load `IDLE_BYTE` and set `slot_valid=1`.
  - FIFO empty, fill disabled: load 0 and set `slot_valid=0`.
- Non-load edge: `shift_reg <= {1'b0, shift_reg[7:1]}`.
- Output decode:
  - `serial_valid = slot_valid`.
  - `byte_strobe = slot_valid && bit_cnt==0`.
- Simultaneous push and pop on a load edge:
  - Count is unchanged.
  - If the FIFO was full, `ready_out` is already low, so only the pop occurs.
  - A byte pushed on the load edge itself into an empty FIFO is not loaded. It goes out in the following slot.
- Pointers are log2(`FIFO_DEPTH`) bits and wrap naturally. The count is a separate register, log2(`FIFO_DEPTH`)+1 bits wide.

## Timing
- Reset values:
  - `bit_cnt=0`, `shift_reg=0`, `slot_valid=0`, FIFO count and pointers 0.
  - Outputs: `serial_out=0`, `serial_valid=0`, `byte_strobe=0`, `ready_out=1`.
- The first load edge is the 8th rising edge after `reset` deasserts.
- A byte is eligible for a slot if it was pushed on any edge strictly before that slot's load edge. It appears during the 8 cycles after the load edge, bit 0 first.
- Minimum latency: push at the `bit_cnt==6` edge → bit 0 on the line after the next edge (1 cycle).
- Maximum latency with an empty FIFO: push on a load edge → 8 cycles.
- Throughput: 1 byte per 8 cycles. Back-to-back slots have no gap.
- Reset asserted mid-byte: on the next edge all state returns to reset values. The partial byte and the FIFO contents are discarded, and the slot phase restarts at `bit_cnt=0`.

## Configuration
- Macro: `PCIE_TX_SERIALIZER_IDLE_FILL_EN`.
- Defined: empty slots carry `IDLE_BYTE` with `serial_valid=1` and `byte_strobe` pulsing. The line is never invalid after the first load edge.
- Undefined: empty slots drive `serial_out=0`, `serial_valid=0` and `byte_strobe=0`.

## Test plan
- Reset, then hold `valid_in=0` for 24 cycles.
  - Fill off: outputs stay 0.
  - Fill on: from cycle 9, serial is 0,0,1,1,1,1,0,1 (0xBC LSB first) repeating, with `byte_strobe` every 8 cycles.
- Push 0xA5 at the `bit_cnt==6` edge → after the next edge, serial shows 1,0,1,0,0,1,0,1 with `byte_strobe` high on the first bit.
- Hold `valid_in=1` continuously with 0x01,0x02,... → `ready_out` drops after 4 accepted bytes plus those popped. Bytes appear in order with no gaps and none are lost or duplicated.
- Push into an empty FIFO exactly on the load edge → the current slot is empty or idle, and the byte is sent in the next slot.
- Assert `reset` at `bit_cnt==3` while 3 bytes are queued → the next cycle shows all outputs 0 and `ready_out=1`. After release, the first load is 8 edges later.
- Fill full and push with `valid_in=1`, `ready_out=0` on a load edge → count goes 4→3, and the blocked byte is not written.

Source files
------------

// File: rtl/pcie_tx_serializer.sv
// PCIe TX parallel-to-serial stage: byte FIFO feeding an LSB-first shifter on clock32.
// Define PCIE_TX_SERIALIZER_IDLE_FILL_EN to send IDLE_BYTE in otherwise empty slots.
module pcie_tx_serializer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  IDLE_BYTE  = 8'hBC
) (
    input  logic       clock32,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       serial_out,
    output logic       serial_valid,
    output logic       byte_strobe
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          slot_valid;

    logic push;
    logic load;
    logic pop;

    always_comb begin
        ready_out    = (count < DEPTH_C);
        push         = valid_in && ready_out;
        load         = (bit_cnt == 3'd7);
        // Pop decision uses the registered count, so a byte written on this
        // same load edge waits for the following slot.
        pop          = load && (count != '0);
        serial_out   = shift_reg[0];
        serial_valid = slot_valid;
        byte_strobe  = slot_valid && (bit_cnt == 3'd0);
    end

    always_ff @(posedge clock32) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clock32) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clock32) begin
        if (reset) begin
            bit_cnt    <= '0;
            shift_reg  <= '0;
            slot_valid <= 1'b0;
        end else begin
            bit_cnt <= bit_cnt + 3'd1;
            if (load) begin
                if (pop) begin
                    shift_reg  <= mem[rd_ptr];
                    slot_valid <= 1'b1;
                end else begin
`ifdef PCIE_TX_SERIALIZER_IDLE_FILL_EN
                    shift_reg  <= IDLE_BYTE;
                    slot_valid <= 1'b1;
`else
                    shift_reg  <= '0;
                    slot_valid <= 1'b0;
`endif
                end
            end else begin
                shift_reg <= {1'b0, shift_reg[7:1]};
            end
        end
    end

endmodule
